// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester (inst/data) arbiter onto one shared SRAM-like bus.
// One transaction outstanding at a time: IDLE grants, REQ issues to memory, WAIT
// collects the response and forwards it to the owner.
// Optional feature: define ARB_RR_EN for round-robin tie resolution; the default
// build uses fixed priority with data beating inst.
module sram_arbiter (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q;
  logic        owner_q;  // 0 = inst, 1 = data
  logic        wr_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic data_prio;
  logic grant_data;
  logic grant_inst;
  logic grant_any;
  logic idle_act;
  logic rsp_fire;

`ifdef ARB_RR_EN
  logic last_q;  // last granted port: 0 = inst, 1 = data

  // Data wins a tie only if inst was granted last.
  always_comb begin
    data_prio = ~last_q;
  end
`else
  // Fixed priority: data always wins a tie.
  always_comb begin
    data_prio = 1'b1;
  end
`endif

  // Winner selection and handshake decode; reset masks every handshake output.
  always_comb begin
    grant_data   = data_req & (~inst_req | data_prio);
    grant_inst   = inst_req & ~grant_data;
    grant_any    = grant_data | grant_inst;
    idle_act     = resetn && (state_q == StIdle);
    rsp_fire     = resetn && (state_q == StWait) && mem_data_ok;

    inst_addr_ok = idle_act & grant_inst;
    data_addr_ok = idle_act & grant_data;
    inst_data_ok = rsp_fire & ~owner_q;
    data_data_ok = rsp_fire & owner_q;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;

    mem_req      = resetn && (state_q == StReq);
    mem_wr       = wr_q;
    mem_size     = size_q;
    mem_wstrb    = wstrb_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
  end

  // Transaction FSM: grant and latch in IDLE, issue in REQ, await response in WAIT.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      wstrb_q <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
`ifdef ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            owner_q <= grant_data;
            wr_q    <= grant_data ? data_wr    : inst_wr;
            size_q  <= grant_data ? data_size  : inst_size;
            wstrb_q <= grant_data ? data_wstrb : inst_wstrb;
            addr_q  <= grant_data ? data_addr  : inst_addr;
            wdata_q <= grant_data ? data_wdata : inst_wdata;
`ifdef ARB_RR_EN
            last_q  <= grant_data;
`endif
            state_q <= StReq;
          end
        end
        StReq: begin
          if (mem_addr_ok) state_q <= StWait;
        end
        StWait: begin
          if (mem_data_ok) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter. Inputs change 1 ns after the
// rising edge; outputs are sampled 1 ns later, well away from the next edge.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One tied request pair carried through to its response.
  task automatic tie(input logic exp_data, input string tag);
    logic exp_inst;
    exp_inst   = exp_data ? 1'b0 : 1'b1;
    inst_req   = 1'b1;
    inst_wr    = 1'b0;
    inst_addr  = 32'h1C00_0100;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_addr  = 32'h0000_2000;
    #1;
    chk({tag, " data_addr_ok"}, data_addr_ok, exp_data);
    chk({tag, " inst_addr_ok"}, inst_addr_ok, exp_inst);
    tick();
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_addr_ok = 1'b1;
    #1;
    chk({tag, " mem_addr"}, mem_addr, exp_data ? 32'h0000_2000 : 32'h1C00_0100);
    tick();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h1234_5678;
    #1;
    chk({tag, " data_data_ok"}, data_data_ok, exp_data);
    chk({tag, " inst_data_ok"}, inst_data_ok, exp_inst);
    tick();
    mem_data_ok = 1'b0;
  endtask

  initial begin
    resetn      = 1'b0;
    inst_req    = 1'b1;
    inst_wr     = 1'b0;
    inst_size   = 2'd2;
    inst_wstrb  = 4'h0;
    inst_addr   = 32'h0;
    inst_wdata  = 32'h0;
    data_req    = 1'b1;
    data_wr     = 1'b0;
    data_size   = 2'd2;
    data_wstrb  = 4'hF;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;

    // Reset holds every handshake low even with requests pending.
    tick();
    tick();
    chk("rst mem_req", mem_req, 1'b0);
    chk("rst inst_addr_ok", inst_addr_ok, 1'b0);
    chk("rst data_addr_ok", data_addr_ok, 1'b0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wr", mem_wr, 1'b0);

    // Single inst read, granted in the first cycle after reset release.
    resetn    = 1'b1;
    data_req  = 1'b0;
    inst_addr = 32'h1C00_0000;
    #1;
    chk("rd inst_addr_ok", inst_addr_ok, 1'b1);
    chk("rd data_addr_ok", data_addr_ok, 1'b0);
    chk("rd mem_req c0", mem_req, 1'b0);
    tick();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    #1;
    chk("rd mem_req c1", mem_req, 1'b1);
    chk("rd mem_addr", mem_addr, 32'h1C00_0000);
    chk("rd mem_wr", mem_wr, 1'b0);
    chk("rd inst_addr_ok c1", inst_addr_ok, 1'b0);
    tick();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0280_0C0C;
    #1;
    chk("rd mem_req wait", mem_req, 1'b0);
    chk("rd inst_data_ok", inst_data_ok, 1'b1);
    chk("rd inst_rdata", inst_rdata, 32'h0280_0C0C);
    chk("rd data_data_ok", data_data_ok, 1'b0);
    tick();
    // Stray mem_data_ok in IDLE is ignored.
    #1;
    chk("idle stray inst_data_ok", inst_data_ok, 1'b0);
    chk("idle stray data_data_ok", data_data_ok, 1'b0);
    mem_data_ok = 1'b0;
    tick();

    // Tie under fixed priority (first tie after reset also goes to data under round-robin).
    inst_req   = 1'b1;
    inst_addr  = 32'h1C00_0004;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_addr  = 32'h0000_1000;
    data_wdata = 32'hDEAD_BEEF;
    data_wstrb = 4'hF;
    #1;
    chk("tie data_addr_ok", data_addr_ok, 1'b1);
    chk("tie inst_addr_ok", inst_addr_ok, 1'b0);
    tick();
    data_req = 1'b0;
    #1;
    chk("tie mem_req", mem_req, 1'b1);
    chk("tie mem_wr", mem_wr, 1'b1);
    chk("tie mem_addr", mem_addr, 32'h0000_1000);
    chk("tie mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("tie mem_wstrb", mem_wstrb, 4'hF);

    // Memory stall: inst keeps requesting with a moving address.
    for (int i = 0; i < 5; i++) begin
      inst_addr   = 32'h1C00_0010 + 32'(i * 4);
      mem_data_ok = (i == 2);
      #1;
      chk("stall mem_req", mem_req, 1'b1);
      chk("stall mem_addr", mem_addr, 32'h0000_1000);
      chk("stall inst_addr_ok", inst_addr_ok, 1'b0);
      chk("stall data_addr_ok", data_addr_ok, 1'b0);
      chk("stall data_data_ok", data_data_ok, 1'b0);
      tick();
    end
    mem_data_ok = 1'b0;
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    #1;
    chk("wait mem_req", mem_req, 1'b0);
    chk("wait mem_addr held", mem_addr, 32'h0000_1000);
    chk("wait inst_addr_ok", inst_addr_ok, 1'b0);
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hCAFE_0001;
    #1;
    chk("tie data_data_ok", data_data_ok, 1'b1);
    chk("tie inst_data_ok", inst_data_ok, 1'b0);
    chk("tie data_rdata", data_rdata, 32'hCAFE_0001);
    chk("no grant on data_ok", inst_addr_ok, 1'b0);
    tick();
    mem_data_ok = 1'b0;
    #1;
    chk("inst granted after", inst_addr_ok, 1'b1);
    tick();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    #1;
    chk("inst mem_addr", mem_addr, 32'h1C00_0020);
    chk("inst mem_wr", mem_wr, 1'b0);
    tick();
    mem_addr_ok = 1'b0;

    // Reset while in WAIT abandons the transaction.
    resetn = 1'b0;
    #1;
    chk("rstwait mem_req", mem_req, 1'b0);
    tick();
    resetn      = 1'b1;
    mem_data_ok = 1'b1;
    data_req    = 1'b1;
    data_wr     = 1'b0;
    data_addr   = 32'h0000_3000;
    #1;
    chk("rstwait inst_data_ok", inst_data_ok, 1'b0);
    chk("rstwait data_data_ok", data_data_ok, 1'b0);
    chk("rstwait fields cleared", mem_addr, 32'h0);
    chk("rstwait new grant", data_addr_ok, 1'b1);
    tick();
    data_req    = 1'b0;
    mem_data_ok = 1'b0;
    #1;
    chk("rstwait mem_req", mem_req, 1'b1);
    chk("rstwait mem_addr", mem_addr, 32'h0000_3000);
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    tick();
    mem_data_ok = 1'b0;

    // Three back-to-back ties from a fresh reset.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tie(1'b1, "tie#1");
    tie(RrEn ? 1'b0 : 1'b1, "tie#2");
    tie(1'b1, "tie#3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
